booth_seq_ctrl: RTL



---
 rtl/booth_seq_ctrl_if.sv | 35 +++
 rtl/booth_seq_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl_if.sv
// booth_seq_ctrl_if
// Handshake and decoder bundle for the iterative radix-4 Booth sequencer.
//   in_valid / in_ready          : operand handshake (producer -> sequencer)
//   multiplicand / multiplier    : signed operands A and B
//   dec_multiplicand / dec_op    : request to the shared Booth decoder
//   dec_pp                       : sign-extended partial product from the decoder
//   out_valid / out_ready        : product handshake (sequencer -> consumer)
//   product                      : 2*WIDTH-bit signed result
//   busy                         : sequencer is running or holding a result
// The slave modport is the sequencer's view; master is the environment's view.
interface booth_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [WIDTH-1:0]       dec_multiplicand;
  logic [2:0]             dec_op;
  logic [2*WIDTH-1:0]     dec_pp;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  modport slave (
    input  in_valid, multiplicand, multiplier, dec_pp, out_ready,
    output in_ready, dec_multiplicand, dec_op, out_valid, product, busy
  );

  modport master (
    output in_valid, multiplicand, multiplier, dec_pp, out_ready,
    input  in_ready, dec_multiplicand, dec_op, out_valid, product, busy
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl
// Iterative radix-4 Booth multiplier sequencer. Accepts a signed operand pair,
// scans the multiplier two bits per cycle, drives a shared Booth decoder with
// the op code for each step and accumulates the returned partial product at
// weight 4^step. After WIDTH/2 steps the 2*WIDTH-bit signed product is held
// until the consumer accepts it.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : booth_seq_ctrl_if.slave (operand/product handshakes, decoder link)
// All outputs come straight from registers.
module booth_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  booth_seq_ctrl_if.slave  bus
);

  localparam int STEPS = WIDTH / 2;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [SW-1:0]        step_r;
  logic [2:0]           dec_op_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic                 accept_s;
  logic                 last_s;
  logic [2:0]           op_next_s;

  // Radix-4 Booth recoding of one overlapping multiplier triplet.
  function automatic logic [2:0] booth_enc(input logic [2:0] t);
    logic [2:0] op;
    case (t)
      3'b001, 3'b010: op = 3'b001;  // +A
      3'b011:         op = 3'b011;  // +2A
      3'b100:         op = 3'b100;  // -2A
      3'b101, 3'b110: op = 3'b010;  // -A
      default:        op = 3'b000;  // 000 / 111 -> zero
    endcase
    return op;
  endfunction

  // Triplet {b[2i+1], b[2i], b[2i-1]} with b[-1] = 0, taken from {b, 0}.
  function automatic logic [2:0] triplet(input logic [WIDTH-1:0] b,
                                         input logic [SW-1:0]    idx);
    logic [WIDTH:0] ext;
    ext = {b, 1'b0} >> {idx, 1'b0};
    return ext[2:0];
  endfunction

  // Next-state logic; also precomputes the op code for the coming RUN cycle
  // so dec_op can be a register that is stable across the whole step.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    last_s    = (step_r == LAST_STEP);
    op_next_s = 3'b000;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // Step 0 triplet comes from the operand being captured this edge.
    if (accept_s) begin
      op_next_s = booth_enc(triplet(bus.multiplier, {SW{1'b0}}));
    end else if ((state_r == RUN) && !last_s) begin
      op_next_s = booth_enc(triplet(b_r, step_r + SW'(1)));
    end else begin
      op_next_s = 3'b000;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, accumulation and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      step_r      <= {SW{1'b0}};
      dec_op_r    <= 3'b000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      dec_op_r    <= op_next_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
      if (accept_s) begin
        a_r    <= bus.multiplicand;
        b_r    <= bus.multiplier;
        acc_r  <= {(2*WIDTH){1'b0}};
        step_r <= {SW{1'b0}};
      end else if (state_r == RUN) begin
        // Partial product weight is 4^step; wraparound modulo 2^(2*WIDTH)
        // is intended and gives the exact signed result.
        acc_r  <= acc_r + (bus.dec_pp << {step_r, 1'b0});
        step_r <= step_r + SW'(1);
      end else begin
        acc_r  <= acc_r;
        step_r <= step_r;
      end
    end
  end

  assign bus.in_ready         = in_ready_r;
  assign bus.out_valid        = out_valid_r;
  assign bus.busy             = busy_r;
  assign bus.dec_op           = dec_op_r;
  assign bus.dec_multiplicand = a_r;
  assign bus.product          = acc_r;

endmodule
